// File: rtl/display_buffer_uart_tx.sv
// Snapshots DisplayBuffer and streams it over an 8N1 UART line, MSB byte first.
// Define DISPLAY_UART_HEX_ENCODE_EN to send each byte as two ASCII hex chars plus CR LF.
module display_buffer_uart_tx #(
  parameter int DisplayBufferSize = 256,
  parameter int ClkDiv            = 868
) (
  input  logic                         clk,
  input  logic                         RESET,
  input  logic [DisplayBufferSize-1:0] DisplayBuffer,
  input  logic                         SEND,
  input  logic                         AUTO,
  output logic                         TXD,
  output logic                         BUSY,
  output logic                         FRAME_DONE
);

  localparam int NBYTES = DisplayBufferSize / 8;
`ifdef DISPLAY_UART_HEX_ENCODE_EN
  localparam int NCHAR = 2 * NBYTES + 2;
`else
  localparam int NCHAR = NBYTES;
`endif
  localparam int CH_W  = (NCHAR > 1) ? $clog2(NCHAR) : 1;
  localparam int DIV_W = $clog2(ClkDiv);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ClkDiv - 1);
  localparam logic [CH_W-1:0]  CHAR_LAST = CH_W'(NCHAR - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Byte idx of the buffer, counting from the most significant byte.
  function automatic logic [7:0] byte_at(input logic [DisplayBufferSize-1:0] data,
                                         input logic [CH_W-1:0] idx);
    logic [DisplayBufferSize-1:0] shifted;
    shifted = data << {idx, 3'b000};
    return shifted[DisplayBufferSize-1 -: 8];
  endfunction

`ifdef DISPLAY_UART_HEX_ENCODE_EN
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return {4'h3, nib};
    end else begin
      return 8'h37 + {4'h0, nib};
    end
  endfunction

  function automatic logic [7:0] char_at(input logic [DisplayBufferSize-1:0] data,
                                         input logic [CH_W-1:0] idx);
    logic [7:0] b;
    b = byte_at(data, {1'b0, idx[CH_W-1:1]});
    if (idx == CH_W'(2 * NBYTES)) begin
      return 8'h0D;
    end else if (idx == CH_W'(2 * NBYTES + 1)) begin
      return 8'h0A;
    end else if (idx[0] == 1'b0) begin
      return hex_ascii(b[7:4]);
    end else begin
      return hex_ascii(b[3:0]);
    end
  endfunction
`else
  function automatic logic [7:0] char_at(input logic [DisplayBufferSize-1:0] data,
                                         input logic [CH_W-1:0] idx);
    return byte_at(data, idx);
  endfunction
`endif

  state_t                       state_r, state_s;
  logic [DIV_W-1:0]             div_r, div_s;
  logic [2:0]                   bit_r, bit_s;
  logic [CH_W-1:0]              char_r, char_s;
  logic [DisplayBufferSize-1:0] snap_r, snap_s;
  logic [DisplayBufferSize-1:0] last_r, last_s;
  logic                         txd_r, txd_s;
  logic                         busy_r;
  logic                         done_r, done_s;
  logic [7:0]                   cur_char_s;
  logic                         tick_s;
  logic                         trigger_s;

  assign tick_s    = (div_r == DIV_LAST);
  assign trigger_s = SEND | (AUTO & (DisplayBuffer != last_r));

  // Next-state, counter and serial-bit computation; TXD is derived from the next state so it is registered.
  always_comb begin
    state_s    = state_r;
    div_s      = div_r;
    bit_s      = bit_r;
    char_s     = char_r;
    snap_s     = snap_r;
    last_s     = last_r;
    done_s     = 1'b0;
    txd_s      = 1'b1;
    cur_char_s = 8'h00;
    case (state_r)
      IDLE: begin
        div_s = '0;
        if (trigger_s) begin
          state_s = START;
          snap_s  = DisplayBuffer;
          last_s  = DisplayBuffer;
          char_s  = '0;
          bit_s   = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          div_s   = '0;
          bit_s   = 3'd0;
          state_s = DATA;
        end else begin
          div_s = div_r + 1'b1;
        end
      end
      DATA: begin
        if (tick_s) begin
          div_s = '0;
          if (bit_r == 3'd7) begin
            state_s = STOP;
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          div_s = div_r + 1'b1;
        end
      end
      STOP: begin
        if (tick_s) begin
          div_s = '0;
          if (char_r == CHAR_LAST) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            char_s  = char_r + 1'b1;
            state_s = START;
          end
        end else begin
          div_s = div_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        div_s   = '0;
      end
    endcase
    cur_char_s = char_at(snap_s, char_s);
    case (state_s)
      START:   txd_s = 1'b0;
      DATA:    txd_s = cur_char_s[bit_s];
      default: txd_s = 1'b1;
    endcase
  end

  // State and output registers; reset drops any frame in flight and forces the line idle at once.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
      div_r   <= '0;
      bit_r   <= 3'd0;
      char_r  <= '0;
      snap_r  <= '0;
      last_r  <= '0;
      txd_r   <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      bit_r   <= bit_s;
      char_r  <= char_s;
      snap_r  <= snap_s;
      last_r  <= last_s;
      txd_r   <= txd_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= done_s;
    end
  end

  assign TXD        = txd_r;
  assign BUSY       = busy_r;
  assign FRAME_DONE = done_r;

endmodule
